// File: rtl/nmr_bstrm_pkg.sv
// Shared definitions for the NMR bitstream player.
// Contents:
//   state_t  - player FSM states (IDLE, LOAD, RUN, DONE)
//   last_pos / chan_msb / chan_lsb / dur_w - word field positions as
//   functions of the FIFO word width and channel count.
// Word layout: [BW-1] = LAST, [BW-2 -: NCH] = channel levels,
// [DUR_W-1:0] = DUR, with DUR_W = BW-1-NCH (must be >= 1).
package nmr_bstrm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int last_pos(input int bw);
    return bw - 1;
  endfunction

  function automatic int chan_msb(input int bw);
    return bw - 2;
  endfunction

  function automatic int chan_lsb(input int bw, input int nch);
    return bw - 1 - nch;
  endfunction

  function automatic int dur_w(input int bw, input int nch);
    return bw - 1 - nch;
  endfunction

endpackage

// File: rtl/nmr_bstrm_player_if.sv
// FIFO read port between the SoC-filled show-ahead bitstream FIFO and the
// player.
// Signals:
//   bitstr_in - head word of the FIFO (valid whenever EMPTY is low)
//   EMPTY     - FIFO empty flag
//   READY     - pop request from the player
// Handshake: the head word is consumed at a rising edge exactly when READY
// is high in the cycle before that edge. The player only raises READY while
// EMPTY is low, so READY alone marks a transfer; at most one pop per cycle.
// Modports: master = FIFO side, slave = player side.
interface nmr_bstrm_player_if #(
  parameter int BUS_WIDTH = 32
);
  logic [BUS_WIDTH-1:0] bitstr_in;
  logic                 EMPTY;
  logic                 READY;

  modport master (output bitstr_in, output EMPTY, input READY);
  modport slave  (input bitstr_in, input EMPTY, output READY);
endinterface

// File: rtl/nmr_bstrm_dur_cnt.sv
// Word-duration counter for the bitstream player.
// Ports:
//   clk, rst  - clock, synchronous active-low reset (count -> 0)
//   load      - load load_val (takes priority over dec)
//   dec       - decrement by one, saturating at zero
//   load_val  - DUR field of the word being latched
//   zero      - count is zero (current word is in its final cycle)
module nmr_bstrm_dur_cnt #(
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/nmr_bstrm_player.sv
// NMR pulse-sequence bitstream player.
// Pops packed words from a show-ahead FIFO and drives NCH channel lines,
// each word for DUR+1 cycles; consecutive words play back to back.
// Ports:
//   CLK, RST   - clock, synchronous active-low reset
//   START      - one-cycle start pulse, accepted only in IDLE
//   STOP       - abort request, wins over START, ends via DONE
//   fifo       - FIFO read port (bitstr_in, EMPTY in; READY out)
//   bstr_out   - registered channel lines (IDLE_LEVEL when not playing)
//   BUSY       - high in LOAD/RUN
//   D_END      - one-cycle end-of-sequence pulse (DONE state)
//   UNDERRUN   - sticky underrun flag
//   state_dbg  - current FSM state
// Build option: NMR_BSTRM_UNDERRUN_ABORT_EN. When defined, running out of
// words before a LAST word aborts the sequence and sets UNDERRUN. When not
// defined, the current levels are held and the player waits in LOAD for
// the next word; UNDERRUN stays 0.
module nmr_bstrm_player
  import nmr_bstrm_pkg::*;
#(
  parameter int             BUS_WIDTH  = 32,
  parameter int             NCH        = 8,
  parameter logic [NCH-1:0] IDLE_LEVEL = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  nmr_bstrm_player_if.slave    fifo,
  output logic [NCH-1:0]       bstr_out,
  output logic                 BUSY,
  output logic                 D_END,
  output logic                 UNDERRUN,
  output state_t               state_dbg
);
  localparam int CNT_W    = dur_w(BUS_WIDTH, NCH);
  localparam int LAST_POS = last_pos(BUS_WIDTH);
  localparam int CH_MSB   = chan_msb(BUS_WIDTH);
  localparam int CH_LSB   = chan_lsb(BUS_WIDTH, NCH);

  state_t           state, state_nxt;
  logic             pop;
  logic             last_q;
  logic             cnt_zero;
  logic             head_last;
  logic [NCH-1:0]   head_lv;
  logic [CNT_W-1:0] head_dur;

  assign head_last = fifo.bitstr_in[LAST_POS];
  assign head_lv   = fifo.bitstr_in[CH_MSB:CH_LSB];
  assign head_dur  = fifo.bitstr_in[CNT_W-1:0];

`ifdef NMR_BSTRM_UNDERRUN_ABORT_EN
  logic underrun_evt;
  logic underrun_q;
`endif

  nmr_bstrm_dur_cnt #(.CNT_W(CNT_W)) u_dur_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (pop),
    .dec      (state == RUN),
    .load_val (head_dur),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
`ifdef NMR_BSTRM_UNDERRUN_ABORT_EN
    underrun_evt = 1'b0;
`endif
    case (state)
      IDLE: if (START && !STOP) state_nxt = LOAD;
      LOAD: begin
        if (STOP) begin
          state_nxt = DONE;
        end else if (!fifo.EMPTY) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (STOP) begin
          state_nxt = DONE;
        end else if (cnt_zero) begin
          if (last_q) begin
            state_nxt = DONE;
          end else if (!fifo.EMPTY) begin
            // Gapless: next word is latched on the edge that ends this one.
            pop = 1'b1;
          end else begin
`ifdef NMR_BSTRM_UNDERRUN_ABORT_EN
            underrun_evt = 1'b1;
            state_nxt    = DONE;
`else
            // Hold current levels; LOAD resumes as soon as a word arrives.
            state_nxt = LOAD;
`endif
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      bstr_out <= IDLE_LEVEL;
      last_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        bstr_out <= head_lv;
        last_q   <= head_last;
      end else if (state_nxt == DONE) begin
        bstr_out <= IDLE_LEVEL;
      end
    end
  end

`ifdef NMR_BSTRM_UNDERRUN_ABORT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      underrun_q <= 1'b0;
    end else if (state == IDLE && START && !STOP) begin
      underrun_q <= 1'b0;
    end else if (underrun_evt) begin
      underrun_q <= 1'b1;
    end
  end
  assign UNDERRUN = underrun_q;
`else
  assign UNDERRUN = 1'b0;
`endif

  assign fifo.READY = pop;
  assign BUSY       = (state == LOAD) || (state == RUN);
  assign D_END      = (state == DONE);
  assign state_dbg  = state;
endmodule

// File: tb/tb_nmr_bstrm_player.sv
// Bench for nmr_bstrm_player. Main DUT: BUS_WIDTH=32, NCH=8, idle level 0.
// Second DUT: BUS_WIDTH=16, NCH=4, idle level 4'h5, for the maximum
// duration boundary (DUR=11'h7FF -> 2048 cycles).
// Expected outputs come from a per-cycle trace built from the word list:
// each word contributes DUR+1 cycles of its levels, framed by the START
// cycle, one LOAD cycle and one D_END cycle.
module tb_nmr_bstrm_player;
  import nmr_bstrm_pkg::*;

  localparam int W = 11;  // {UNDERRUN, D_END, BUSY, bstr_out[7:0]}

  logic clk;
  logic rst, start, stop;
  logic [7:0] bstr_out;
  logic busy, d_end, underrun;
  state_t state_dbg;

  logic start2;
  logic [3:0] bstr2;
  logic busy2, d_end2, underrun2;
  state_t state_dbg2;

  nmr_bstrm_player_if #(.BUS_WIDTH(32)) f ();
  nmr_bstrm_player_if #(.BUS_WIDTH(16)) f2 ();

  nmr_bstrm_player #(.BUS_WIDTH(32), .NCH(8), .IDLE_LEVEL(8'h00)) dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .fifo(f.slave),
    .bstr_out(bstr_out), .BUSY(busy), .D_END(d_end), .UNDERRUN(underrun),
    .state_dbg(state_dbg)
  );

  nmr_bstrm_player #(.BUS_WIDTH(16), .NCH(4), .IDLE_LEVEL(4'h5)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .STOP(1'b0), .fifo(f2.slave),
    .bstr_out(bstr2), .BUSY(busy2), .D_END(d_end2), .UNDERRUN(underrun2),
    .state_dbg(state_dbg2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [31:0]  fifo_q[$];
  logic         idle_u;
  int n_checks, n_errors, n_pops, busy_cnt, dend_cnt, cyc;

  function automatic logic [W-1:0] mk(input logic u, input logic d,
                                      input logic b, input logic [7:0] lv);
    return {u, d, b, lv};
  endfunction

  function automatic logic [31:0] wd(input logic last, input logic [7:0] lv,
                                     input logic [22:0] dur);
    return {last, lv, dur};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // model: sequence framing and per-word playback
  task automatic exp_begin();
    exp_q.push_back(mk(idle_u, 1'b0, 1'b0, 8'h00));  // START cycle, IDLE
    idle_u = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00));    // LOAD cycle
  endtask

  task automatic exp_play(input logic [7:0] lv, input int n);
    repeat (n) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, lv));
  endtask

  task automatic exp_end(input logic u);
    exp_q.push_back(mk(u, 1'b1, 1'b0, 8'h00));
    idle_u = u;
  endtask

  // driver + compare, one clock cycle per call
  task automatic step(input logic s, input logic p, input logic r);
    logic [W-1:0] exp_v, act_v;
    @(negedge clk);
    start       = s;
    stop        = p;
    rst         = r;
    f.EMPTY     = (fifo_q.size() == 0);
    f.bitstr_in = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    #1;
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front()
                                : mk(idle_u, 1'b0, 1'b0, 8'h00);
    act_v = {underrun, d_end, busy, bstr_out};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL outputs cyc=%0d u/dend/busy/out got %b/%b/%b/%h expected %b/%b/%b/%h",
               cyc, act_v[10], act_v[9], act_v[8], act_v[7:0],
               exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
    end
    n_checks++;
    if (f.READY === 1'b1 && f.EMPTY === 1'b1) begin
      n_errors++;
      $display("FAIL ready_while_empty cyc=%0d got READY=1 expected 0", cyc);
    end
    busy_cnt += int'(busy);
    dend_cnt += int'(d_end);
    if (f.READY === 1'b1 && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      n_pops++;
    end
    cyc++;
  endtask

  task automatic scen_reset_counts();
    n_pops = 0; busy_cnt = 0; dend_cnt = 0;
  endtask

  int hold2, pops2, ends2, end_at2;
  logic popped2;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; idle_u = 1'b0;
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    f.EMPTY = 1'b1; f.bitstr_in = '0;
    start2 = 1'b0; f2.EMPTY = 1'b1; f2.bitstr_in = '0;
    repeat (2) @(negedge clk);

    // reset state
    scen_reset_counts();
    step(1'b0, 1'b0, 1'b0);
    chk("reset_state_idle", int'(state_dbg), int'(IDLE));
    chk("reset_dut2_idle_level", int'(bstr2), 5);
    chk("reset_dut2_busy", int'(busy2), 0);
    step(1'b0, 1'b0, 1'b1);

    // two words, gapless, LAST on the second
    scen_reset_counts();
    fifo_q.push_back(wd(1'b0, 8'hA5, 23'd3));
    fifo_q.push_back(wd(1'b1, 8'h3C, 23'd0));
    exp_begin(); exp_play(8'hA5, 4); exp_play(8'h3C, 1); exp_end(1'b0);
    for (int i = 0; i < 10; i++) step(i == 0, 1'b0, 1'b1);
    chk("two_word_pops", n_pops, 2);
    chk("two_word_busy_cycles", busy_cnt, 6);
    chk("two_word_dend_pulses", dend_cnt, 1);

    // single word, DUR=0, LAST
    scen_reset_counts();
    fifo_q.push_back(wd(1'b1, 8'h5A, 23'd0));
    exp_begin(); exp_play(8'h5A, 1); exp_end(1'b0);
    for (int i = 0; i < 6; i++) step(i == 0, 1'b0, 1'b1);
    chk("single_word_pops", n_pops, 1);
    chk("single_word_busy_cycles", busy_cnt, 2);

    // underrun: second word arrives 5 cycles after the first word's end
    scen_reset_counts();
    fifo_q.push_back(wd(1'b0, 8'hA5, 23'd3));
    exp_begin(); exp_play(8'hA5, 4);
`ifdef NMR_BSTRM_UNDERRUN_ABORT_EN
    exp_end(1'b1);
`else
    exp_play(8'hA5, 5); exp_play(8'h3C, 1); exp_end(1'b0);
`endif
    for (int i = 0; i < 16; i++) begin
      if (i == 10) fifo_q.push_back(wd(1'b1, 8'h3C, 23'd0));
      step(i == 0, 1'b0, 1'b1);
    end
`ifdef NMR_BSTRM_UNDERRUN_ABORT_EN
    chk("underrun_pops", n_pops, 1);
    chk("underrun_flag", int'(underrun), 1);
`else
    chk("underrun_pops", n_pops, 2);
    chk("underrun_flag", int'(underrun), 0);
`endif
    fifo_q.delete();

    // STOP two cycles into a DUR=100 word; START+STOP together in IDLE
    scen_reset_counts();
    fifo_q.push_back(wd(1'b0, 8'hF0, 23'd100));
    fifo_q.push_back(wd(1'b1, 8'h0F, 23'd1));
    exp_begin(); exp_play(8'hF0, 2); exp_end(1'b0);
    for (int i = 0; i < 7; i++) step(i == 0 || i == 5, i == 3 || i == 5, 1'b1);
    chk("stop_pops", n_pops, 1);
    chk("stop_dend_pulses", dend_cnt, 1);
    // restart three cycles after D_END
    scen_reset_counts();
    exp_begin(); exp_play(8'h0F, 2); exp_end(1'b0);
    for (int i = 0; i < 7; i++) step(i == 0, 1'b0, 1'b1);
    chk("restart_pops", n_pops, 1);
    chk("restart_fifo_left", fifo_q.size(), 0);

    // reset asserted mid-RUN: no D_END
    scen_reset_counts();
    fifo_q.push_back(wd(1'b1, 8'h77, 23'd20));
    fifo_q.push_back(wd(1'b1, 8'h11, 23'd0));
    exp_begin(); exp_play(8'h77, 3);
    for (int i = 0; i < 8; i++) step(i == 0, 1'b0, i != 4);
    chk("mid_reset_dend_pulses", dend_cnt, 0);
    chk("mid_reset_pops", n_pops, 1);

    // START held while busy must not cause a second pop
    scen_reset_counts();
    fifo_q.push_back(wd(1'b1, 8'h22, 23'd0));
    exp_begin(); exp_play(8'h11, 1); exp_end(1'b0);
    for (int i = 0; i < 7; i++) step(i <= 3, 1'b0, 1'b1);
    chk("start_while_busy_pops", n_pops, 1);
    chk("start_while_busy_fifo_left", fifo_q.size(), 1);
    fifo_q.delete();

    // maximum duration on the 16-bit instance: 2048 cycles
    hold2 = 0; pops2 = 0; ends2 = 0; end_at2 = -1; popped2 = 1'b0;
    f2.bitstr_in = {1'b1, 4'h9, 11'h7FF};
    for (int i = 0; i < 2056; i++) begin
      @(negedge clk);
      start2   = (i == 0);
      f2.EMPTY = popped2;
      #1;
      if (busy2 && bstr2 == 4'h9) hold2++;
      if (d_end2) begin
        ends2++;
        end_at2 = i;
        chk("max_dur_dend_idle_level", int'(bstr2), 5);
      end
      if (f2.READY) begin
        popped2 = 1'b1;
        pops2++;
      end
    end
    chk("max_dur_hold_cycles", hold2, 2048);
    chk("max_dur_pops", pops2, 1);
    chk("max_dur_dend_pulses", ends2, 1);
    chk("max_dur_dend_cycle", end_at2, 2050);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/nmr_bstrm_player.md
Name: nmr_bstrm_player

Overview:
Multi-channel, parametrised successor to the single-bus bitstream FIFO reader. It pops packed words from a show-ahead FIFO and drives NCH pulse-sequencer lines with per-word cycle-accurate durations. Consecutive words play back to back with no gap cycles. It sits between the SoC-filled bitstream FIFO and the NMR TX/RX gating lines, and signals sequence end to the SoC.

Parameters:
BUS_WIDTH, 32, FIFO word width
NCH, 8, number of output channel lines
IDLE_LEVEL, {NCH{1'b0}}, channel levels driven when not playing
CNT_W, BUS_WIDTH-1-NCH (derived localparam, must be >=1), duration field width

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-low
START  in  1  one-cycle pulse, begin playback (sampled only in IDLE)
STOP  in  1  level/pulse abort from SoC, highest priority after reset
bitstr_in  in  BUS_WIDTH  show-ahead FIFO head word
EMPTY  in  1  FIFO empty flag
READY  out  1  FIFO read request, one-cycle pop of current head
bstr_out  out  NCH  registered channel lines
BUSY  out  1  high in LOAD/RUN
D_END  out  1  one-cycle end-of-sequence pulse to SoC
UNDERRUN  out  1  sticky underrun flag (see Optional Feature)

Behaviour:
- Word format: [BUS_WIDTH-1]=LAST; [BUS_WIDTH-2 -: NCH]=channel levels; [CNT_W-1:0]=DUR. The word plays for DUR+1 cycles; DUR=0 gives 1 cycle, and the maximum is 2^CNT_W cycles.
- Reset (RST=0 at edge): state=IDLE, bstr_out=IDLE_LEVEL, READY=0, BUSY=0, D_END=0, UNDERRUN=0, duration counter=0.
- READY is combinational from state, EMPTY and counter. It is never asserted while EMPTY=1, and there is at most one pop per cycle.
- IDLE: bstr_out=IDLE_LEVEL. START=1 and STOP=0 -> LOAD. START outside IDLE is ignored.
- LOAD: if EMPTY=0, assert READY, latch channels/DUR/LAST, go to RUN. If EMPTY=0 is seen at the edge after the START edge, bstr_out shows the word one cycle after that. If EMPTY=1, wait in LOAD with outputs unchanged.
- RUN: the counter decrements each cycle. At counter==0:
  - LAST=1 -> DONE.
  - else EMPTY=0 -> READY=1, the next word is latched at the same edge, stay in RUN (gapless).
  - else underrun (see Optional Feature).
- DONE: lasts one cycle. D_END=1, bstr_out=IDLE_LEVEL, BUSY=0, then -> IDLE. D_END and the idle level appear together in the cycle after the last word's final cycle.
- STOP=1 in LOAD/RUN: at the next edge go to DONE path (D_END pulse, IDLE_LEVEL), no pop that cycle. STOP in IDLE/DONE has no effect. STOP wins over a simultaneous START.
- RST=0 mid-playback: immediate return to reset values, no D_END. FIFO contents are untouched.
- UNDERRUN clears only on reset or on an accepted START.

Optional Feature:
- Macro NMR_BSTRM_UNDERRUN_ABORT_EN.
- Defined: an underrun in RUN (EMPTY=1, counter==0, LAST=0) sets UNDERRUN, forces IDLE_LEVEL and D_END, and goes to IDLE.
- Undefined: on underrun, bstr_out holds the current levels (duration stretched), the block waits in LOAD, and UNDERRUN is tied 0.

Decomposition:
- Package nmr_bstrm_pkg: state enum {IDLE, LOAD, RUN, DONE}; field-position constants for LAST, channel and DUR as functions of BUS_WIDTH/NCH.
- Sub-module nmr_bstrm_dur_cnt (CNT_W): load/decrement counter with zero flag.

Test Plan:
- FIFO holds {0,8'hA5,23'd3},{1,8'h3C,23'd0}; START pulse -> bstr_out=A5 for 4 cycles, 3C for 1 cycle, then 00 with D_END=1 for exactly 1 cycle; 2 READY pulses; no gap cycle.
- Single word with DUR=0 and LAST=1 -> 1-cycle output, D_END on the next cycle, BUSY high 2 cycles total (LOAD, RUN).
- EMPTY=1 for 5 cycles after the first word's end (not LAST) -> without macro: A5 stretched by 5 cycles, UNDERRUN=0. With macro: UNDERRUN=1, D_END pulse, bstr_out=00.
- STOP asserted 2 cycles into a DUR=100 word -> next cycle D_END=1, bstr_out=00, no further READY; START 3 cycles later restarts cleanly.
- RST low during RUN -> all outputs at reset values next cycle, no D_END. START while BUSY is ignored: no second pop.
- Max DUR (23'h7FFFFF) with BUS_WIDTH=32, NCH=8 -> output held 8388608 cycles (or BUS_WIDTH=16, NCH=4, DUR=11'h7FF -> 2048 cycles).
